dtpm_block_packer: RTL
======================

Name: dtpm_block_packer

Overview:
- Sits between the DTPM fetch-side controller and the GCM hash core.
- Accepts byte-lane-qualified instruction words (1–4 bytes each) and concatenates them into a byte stream.
- Packs the stream into left-aligned 128-bit blocks with a byte-count field and a last-block flag.
- Presents each block on a valid/ready handshake that maps directly onto the core's data-input port, where ready is the inverse of the core's not-ready signal.

Parameters:
- IN_WIDTH, 32, instruction word width in bits; fixed at 32 and not otherwise supported.
- BLK_WIDTH, 128, block width in bits; fixed at 128 and not otherwise supported.

Ports:
- clock  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush; discards all partial and pending data.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  32  instruction bytes, right-aligned.
- in_sel  input  4  byte-lane mask; legal values are 4'h1, 4'h3, 4'h7, 4'hF.
- in_last  input  1  word is the final word of the basic block.
- blk_valid  output  1  output block valid.
- blk_ready  input  1  consumer accepts the block.
- blk_data  output  128  packed block; first stream byte in [127:120], unused low bytes zero.
- blk_size  output  4  number of valid bytes minus 1 (0..15).
- blk_last  output  1  final block of the basic block.

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: blk_valid=0, blk_data=0, blk_size=0, blk_last=0, in_ready=0.
  - Internal: acc=0, acc_cnt=0, state=ACCUM.
  - in_ready rises on the first clock after reset release.
- Input handshake:
  - A word transfers when in_valid & in_ready.
  - n = bytes in the word, from in_sel (1, 2, 3 or 4).
  - Byte order: in_data[8n-1:8n-8] is the earliest byte; in_data[7:0] is the latest.
  - Stream effect: acc = (acc << 8n) | in_data[8n-1:0].
- in_ready = (state==ACCUM) & (!blk_valid | blk_ready). It is combinational from registered state and blk_ready.
- Output handshake:
  - blk_* registers hold steady while blk_valid & !blk_ready.
  - blk_valid clears on blk_ready unless a new block loads in the same cycle.
- Emission, when accepting a word with t = acc_cnt + n:
  - t<16, in_last=0: acc_cnt=t; no block emitted.
  - t<16, in_last=1: emit next cycle with blk_data = acc << 8*(16-t), blk_size=t-1, blk_last=1; then acc_cnt=0.
  - t==16: emit a full block, blk_size=15, blk_last=in_last; acc_cnt=0.
  - t>16 (split word): the leading 16-acc_cnt bytes complete a block, blk_size=15, blk_last=0. The trailing t-16 bytes stay in acc with acc_cnt=t-16.
  - t>16 with in_last=1: go to state TAIL.
- Latency: a block is visible on blk_* on the clock edge that accepts its completing word, i.e. one cycle after the handshake cycle.
- State machine:
  - ACCUM: normal packing as above.
  - TAIL: in_ready=0. When blk_valid=0, or blk_ready=1 in the current cycle, load the tail block (acc left-aligned, blk_size=acc_cnt-1, blk_last=1). Then acc_cnt=0 and return to ACCUM.
- Illegal in_sel (not 1/3/7/F): the word is accepted and treated as n=0. Stream, acc and acc_cnt are unchanged; an accompanying in_last is ignored.
- clear:
  - Synchronous; highest priority below reset.
  - Sets blk_valid=0, acc=0, acc_cnt=0, state=ACCUM.
  - A word presented in the same cycle is dropped.
- Simultaneous blk_ready and a block-completing input: the old block retires and the new one loads in the same edge; no bubble.
- Widths: acc_cnt is 5 bits (0..16); t is computed in 5 bits (max 15+4=19 does not overflow).

Optional Feature:
- Macro: DTPM_PACK_ERR_EN.
- When defined:
  - Adds output sel_err (1 bit, reset 0). It is sticky, set on any accepted word with illegal in_sel, and cleared only by clear or reset.
  - Adds output blk_count (16 bits, reset 0). It increments on each blk_valid & blk_ready, wraps at 16'hFFFF→0, and is cleared by clear.
- When undefined: neither port exists; illegal-sel handling is otherwise identical.

Test Plan:
- Four words, in_sel=F, data 00010203, 04050607, 08090A0B, 0C0D0E0F, last on the 4th, blk_ready=1 → one block, blk_data=000102…0E0F, blk_size=15, blk_last=1, one cycle after the 4th handshake.
- Words F:AABBCCDD, 3:xxxx1122, last=1 → blk_data=AABBCCDD1122 followed by 80 zero bits, blk_size=5, blk_last=1.
- Four 4-byte words then 3:xxxx5566 (no last), 4-byte word 778899AA with last:
  - Block 1 is the 16 bytes, blk_size=15, blk_last=0.
  - Block 2 is 5566778899AA left-aligned, blk_size=5, blk_last=1.
- Split: 14 bytes accumulated, then F:11223344 with last, blk_ready=1:
  - Block 1 ends …1122, blk_size=15, blk_last=0.
  - in_ready=0 for one cycle (TAIL).
  - Block 2 is 3344 followed by zeros, blk_size=1, blk_last=1.
- Backpressure: blk_ready=0 with a full block pending → in_ready=0, blk_* stable for 10 cycles; on blk_ready=1, in_ready rises the same cycle and no bytes are lost or duplicated.
- Illegal in_sel=4'h5 mid-stream → stream unaffected; with DTPM_PACK_ERR_EN, sel_err=1 until clear. Assert clear with 6 bytes held → next block contains only post-clear bytes; reset_n low mid-block → all outputs 0 immediately.

Source files
------------

// File: rtl/dtpm_block_packer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | dtpm_word_if / dtpm_blk_if                                                  |
// | Instruction-word input bus and packed-block output bus of the block packer. |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+

interface dtpm_word_if #(
   parameter int IN_WIDTH = 32
) ();
   logic                  in_valid;
   logic                  in_ready;
   logic [IN_WIDTH-1:0]   in_data;
   logic [3:0]            in_sel;
   logic                  in_last;

   modport master (output in_valid, output in_data, output in_sel, output in_last, input in_ready);
   modport slave  (input in_valid, input in_data, input in_sel, input in_last, output in_ready);
endinterface

interface dtpm_blk_if #(
   parameter int BLK_WIDTH = 128
) ();
   logic                  blk_valid;
   logic                  blk_ready;
   logic [BLK_WIDTH-1:0]  blk_data;
   logic [3:0]            blk_size;
   logic                  blk_last;

   modport master (output blk_valid, output blk_data, output blk_size, output blk_last, input blk_ready);
   modport slave  (input blk_valid, input blk_data, input blk_size, input blk_last, output blk_ready);
endinterface

`default_nettype wire

// File: rtl/dtpm_block_packer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | dtpm_block_packer                                                           |
// | Packs 1-4 byte instruction words into left-aligned 128-bit hash blocks.     |
// | Optional macro DTPM_PACK_ERR_EN adds sel_err and blk_count outputs.         |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+

module dtpm_block_packer #(
   parameter int IN_WIDTH  = 32,
   parameter int BLK_WIDTH = 128
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         clear,
   dtpm_word_if.slave   word,
   dtpm_blk_if.master   blk
`ifdef DTPM_PACK_ERR_EN
   ,
   output logic         sel_err,
   output logic [15:0]  blk_count
`endif
);

   localparam int c_CAT_W = BLK_WIDTH + IN_WIDTH;

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_TAIL  = 1'b1
   } state_t;

   state_t                 r_state, w_state_nxt;
   logic                   r_run;
   logic [BLK_WIDTH-1:0]   r_acc, w_acc_nxt;
   logic [4:0]             r_acc_cnt, w_cnt_nxt;
   logic                   r_blk_valid, w_bv_nxt;
   logic [BLK_WIDTH-1:0]   r_blk_data, w_bd_nxt;
   logic [3:0]             r_blk_size, w_bs_nxt;
   logic                   r_blk_last, w_bl_nxt;

   logic [2:0]             w_n;
   logic [4:0]             w_t;
   logic [IN_WIDTH-1:0]    w_word;
   logic [c_CAT_W-1:0]     w_cat;
   logic [7:0]             w_lsh;
   logic [7:0]             w_rsh;
   logic [7:0]             w_tsh;
   logic [BLK_WIDTH-1:0]   w_blk_new;
   logic [IN_WIDTH-1:0]    w_rem;
   logic [BLK_WIDTH-1:0]   w_tail;
   logic                   w_fire;
   logic                   w_retire;

   always_comb begin
      case (word.in_sel)
         4'h1:    w_n = 3'd1;
         4'h3:    w_n = 3'd2;
         4'h7:    w_n = 3'd3;
         4'hF:    w_n = 3'd4;
         default: w_n = 3'd0;
      endcase
   end

   assign word.in_ready = r_run && (r_state == ST_ACCUM) && (!r_blk_valid || blk.blk_ready);
   assign w_fire        = word.in_valid && word.in_ready;
   assign w_retire      = r_blk_valid && blk.blk_ready;

   // Stream is kept right-aligned in w_cat; shifting left by 20-t bytes puts the
   // oldest byte at the top, so the upper 128 bits are the block for any t.
   assign w_word    = word.in_data & {{8{word.in_sel[3]}}, {8{word.in_sel[2]}},
                                      {8{word.in_sel[1]}}, {8{word.in_sel[0]}}};
   assign w_t       = r_acc_cnt + {2'b00, w_n};
   assign w_cat     = ({{IN_WIDTH{1'b0}}, r_acc} << {w_n, 3'b000}) | {{BLK_WIDTH{1'b0}}, w_word};
   assign w_lsh     = {5'd20 - w_t, 3'b000};
   assign w_rsh     = {w_t - 5'd16, 3'b000};
   assign w_tsh     = {5'd16 - r_acc_cnt, 3'b000};
   assign w_blk_new = BLK_WIDTH'((w_cat << w_lsh) >> IN_WIDTH);
   assign w_rem     = w_cat[IN_WIDTH-1:0] & ~({IN_WIDTH{1'b1}} << w_rsh);
   assign w_tail    = r_acc << w_tsh;

   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_cnt_nxt   = r_acc_cnt;
      w_bv_nxt    = r_blk_valid;
      w_bd_nxt    = r_blk_data;
      w_bs_nxt    = r_blk_size;
      w_bl_nxt    = r_blk_last;
      if (clear) begin
         w_bv_nxt    = 1'b0;
         w_acc_nxt   = '0;
         w_cnt_nxt   = '0;
         w_state_nxt = ST_ACCUM;
      end else begin
         if (w_retire) begin
            w_bv_nxt = 1'b0;
         end
         case (r_state)
            ST_ACCUM: begin
               // Words with an illegal lane mask decode to n=0 and leave the stream untouched.
               if (w_fire && (w_n != 3'd0)) begin
                  if ((w_t < 5'd16) && !word.in_last) begin
                     w_acc_nxt = w_cat[BLK_WIDTH-1:0];
                     w_cnt_nxt = w_t;
                  end else begin
                     w_bv_nxt = 1'b1;
                     w_bd_nxt = w_blk_new;
                     if (w_t <= 5'd16) begin
                        w_bs_nxt  = 4'(w_t - 5'd1);
                        w_bl_nxt  = word.in_last;
                        w_acc_nxt = '0;
                        w_cnt_nxt = '0;
                     end else begin
                        w_bs_nxt  = 4'd15;
                        w_bl_nxt  = 1'b0;
                        w_acc_nxt = {{(BLK_WIDTH-IN_WIDTH){1'b0}}, w_rem};
                        w_cnt_nxt = w_t - 5'd16;
                        if (word.in_last) begin
                           w_state_nxt = ST_TAIL;
                        end
                     end
                  end
               end
            end
            ST_TAIL: begin
               if (!r_blk_valid || blk.blk_ready) begin
                  w_bv_nxt    = 1'b1;
                  w_bd_nxt    = w_tail;
                  w_bs_nxt    = 4'(r_acc_cnt - 5'd1);
                  w_bl_nxt    = 1'b1;
                  w_acc_nxt   = '0;
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_ACCUM;
               end
            end
            default: w_state_nxt = ST_ACCUM;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_ACCUM;
         r_run       <= 1'b0;
         r_acc       <= '0;
         r_acc_cnt   <= '0;
         r_blk_valid <= 1'b0;
         r_blk_data  <= '0;
         r_blk_size  <= '0;
         r_blk_last  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_run       <= 1'b1;
         r_acc       <= w_acc_nxt;
         r_acc_cnt   <= w_cnt_nxt;
         r_blk_valid <= w_bv_nxt;
         r_blk_data  <= w_bd_nxt;
         r_blk_size  <= w_bs_nxt;
         r_blk_last  <= w_bl_nxt;
      end
   end

   assign blk.blk_valid = r_blk_valid;
   assign blk.blk_data  = r_blk_data;
   assign blk.blk_size  = r_blk_size;
   assign blk.blk_last  = r_blk_last;

`ifdef DTPM_PACK_ERR_EN
   logic        r_sel_err;
   logic [15:0] r_blk_count;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sel_err   <= 1'b0;
         r_blk_count <= '0;
      end else if (clear) begin
         r_sel_err   <= 1'b0;
         r_blk_count <= '0;
      end else begin
         if (w_fire && (w_n == 3'd0)) begin
            r_sel_err <= 1'b1;
         end
         if (w_retire) begin
            r_blk_count <= r_blk_count + 16'd1;
         end
      end
   end

   assign sel_err   = r_sel_err;
   assign blk_count = r_blk_count;
`endif

endmodule

`default_nettype wire
